path_sequencer: RTL and testbench
=================================

# path_sequencer

Path sequencer for the line-following datapath. It holds a preloaded route of up to `MAX_NODES` nodes, each a node id with the turn to execute there. At each node it drives `turn_flag` into the line follower and tracks the follower's `node_flag`/`node_changed` outputs. It updates `realtime_pos` as each node is cleared and pulses `end_path` when the route is finished.

## Interface
- `MAX_NODES`, default 32: route depth, 2..32; index width 5, length width 6.
- `TIMEOUT_CYCLES`, default 3125000: maximum cycles allowed inside a node (1 s at 3.125 MHz).

Ports (name, direction, width, meaning):
- `clk_3125KHz` in 1: the single system clock.
- `rst` in 1: synchronous, active-high reset.
- `load_valid` in 1: route entry offered.
- `load_ready` out 1: entry accepted when high together with `load_valid`.
- `load_node` in 5: node id of the entry.
- `load_turn` in 2: turn code of the entry.
- `load_last` in 1: marks the final route entry.
- `start` in 1: one-cycle pulse that begins traversal.
- `node_flag` in 1: level from the follower; high while the robot is on a node.
- `node_changed` in 1: one-cycle pulse from the follower when the robot leaves a node.
- `turn_flag` out 2: turn command to the follower.
- `realtime_pos` out 5: id of the last cleared node.
- `end_path` out 1: one-cycle pulse when the route is complete.
- `busy` out 1: high in RUN and NODE.
- `fault` out 1: sticky node-timeout flag.
- `path_len` out 6: number of entries loaded.

## Operation
- States: IDLE, RUN, NODE, DONE, FAULT. Reset enters IDLE.
- Reset values: `turn_flag`=0, `realtime_pos`=0, `end_path`=0, `busy`=0, `fault`=0, `path_len`=0. Internal: `wr_ptr`=0, `rd_idx`=0, `path_valid`=0, `node_flag_d`=0, timeout counter=0.
- `load_ready` = (state==IDLE) && !`path_valid`.
- Load:
  - Each accepted entry is written at `wr_ptr`, then `wr_ptr` increments.
  - When `load_last` is high, or `wr_ptr`==`MAX_NODES`-1, `path_valid` is set and `path_len` = `wr_ptr`+1.
  - An accept at `wr_ptr`==`MAX_NODES`-1 is the implicit last entry.
- IDLE:
  - `start` with `path_valid`=1 goes to RUN: `rd_idx`=0, `turn_flag`=turn[0], `busy`=1.
  - `start` with `path_valid`=0 is ignored.
- RUN:
  - A rising edge of `node_flag` (`node_flag` && !`node_flag_d`) goes to NODE and clears the timeout counter.
  - `node_changed` is ignored in RUN.
  - If `node_flag` is already high when RUN is entered, the sequencer waits for the next rising edge.
- NODE:
  - On `node_changed`, `realtime_pos` = node[`rd_idx`].
  - If `rd_idx`==`path_len`-1: go to DONE.
  - Otherwise: `rd_idx`+1, `turn_flag`=turn[`rd_idx`+1] on the same edge, and return to RUN.
  - The timeout counter increments every cycle. When it reaches `TIMEOUT_CYCLES`-1 without `node_changed`, go to FAULT.
  - If `node_changed` arrives on the terminal-count cycle, `node_changed` wins.
- DONE:
  - Lasts one cycle: `end_path`=1, `turn_flag`=0, `busy`=0, `path_valid`=0, `wr_ptr`=0, then IDLE.
  - `path_len` and `realtime_pos` hold their values until the next load or reset.
- FAULT:
  - `fault`=1, `turn_flag`=0, `busy`=0.
  - Only `rst` exits FAULT; `start` and `load_valid` are ignored.
- `start` and `load_valid` are ignored in RUN, NODE and DONE.
- Turn encoding: 0 straight, 1 right pivot, 2 U-turn, 3 left pivot. The stored 2-bit value is passed through unchecked.

## Timing
- All outputs are registered.
- `start` at edge N: `busy`=1 and `turn_flag` valid after edge N.
- `node_changed` sampled at edge N: new `realtime_pos` and `turn_flag` visible after edge N.
- `end_path` is high for exactly the cycle after the final `node_changed`.
- Edge detection has 0-cycle latency, using `node_flag_d` registered every cycle.
- Timeout fires exactly `TIMEOUT_CYCLES` cycles after NODE entry.
- `rst` mid-route returns every register to its reset value on that edge; the loaded route is discarded.

## Structure
- Package `path_pkg`:
  - Turn constants `TURN_STRAIGHT`/`TURN_RIGHT`/`TURN_UTURN`/`TURN_LEFT`.
  - The state enum.
  - Widths `NODE_W`=5 and `TURN_W`=2.
- One sub-module, `path_store`: a `MAX_NODES`×7-bit register file with one write port and asynchronous read at `rd_idx` and `rd_idx`+1. It is not reset; reads beyond `path_len` are never used.
- The FSM, timeout counter and edge detector stay in the top module.

## Test plan
- Load {(5,0),(12,1),(20,3)} with `load_last` on the third entry, then `start` → `path_len`=3, `turn_flag`=0, `busy`=1.
- On the same route, drive three `node_flag` rise/fall cycles each followed by a `node_changed` pulse → `realtime_pos` steps 5, 12, 20; `turn_flag` steps 0→1→3→0; a single-cycle `end_path` after the third pulse.
- Hold `node_flag` high for `TIMEOUT_CYCLES` in the first node (with `TIMEOUT_CYCLES` reduced to 16) → `fault`=1 on cycle 16, `turn_flag`=0; `start` is ignored; `rst` clears `fault`.
- Load 32 entries without `load_last` → `load_ready` drops after the 32nd accept, `path_len`=32; `start` is accepted.
- `start` with no route loaded, and `node_changed` while in RUN → no state change, `realtime_pos` stays 0.
- Assert `rst` while in NODE at the second node → all outputs return to reset values; `load_ready`=1.

Source files
------------

// File: rtl/path_pkg.sv
// Shared types and widths for the path sequencer: turn codes, FSM states and the route entry payload.
package path_pkg;

  localparam int unsigned NODE_W = 5;
  localparam int unsigned TURN_W = 2;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned LEN_W  = 6;

  localparam logic [TURN_W-1:0] TURN_STRAIGHT = 2'd0;
  localparam logic [TURN_W-1:0] TURN_RIGHT    = 2'd1;
  localparam logic [TURN_W-1:0] TURN_UTURN    = 2'd2;
  localparam logic [TURN_W-1:0] TURN_LEFT     = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_NODE,
    S_DONE,
    S_FAULT
  } seq_state_t;

  typedef struct packed {
    logic [NODE_W-1:0] node;
    logic [TURN_W-1:0] turn;
  } route_entry_t;

endpackage

// File: rtl/path_sequencer_if.sv
// Route load, follower handshake and status bundle between the sequencer and its surroundings.
interface path_sequencer_if;
  import path_pkg::*;

  logic              load_valid;
  logic              load_ready;
  logic [NODE_W-1:0] load_node;
  logic [TURN_W-1:0] load_turn;
  logic              load_last;
  logic              start;
  logic              node_flag;
  logic              node_changed;
  logic [TURN_W-1:0] turn_flag;
  logic [NODE_W-1:0] realtime_pos;
  logic              end_path;
  logic              busy;
  logic              fault;
  logic [LEN_W-1:0]  path_len;

  modport master (
    output load_valid, load_node, load_turn, load_last, start, node_flag, node_changed,
    input  load_ready, turn_flag, realtime_pos, end_path, busy, fault, path_len
  );

  modport slave (
    input  load_valid, load_node, load_turn, load_last, start, node_flag, node_changed,
    output load_ready, turn_flag, realtime_pos, end_path, busy, fault, path_len
  );

endinterface

// File: rtl/path_store.sv
// Route register file: one write port, asynchronous reads of the current and following entry.
module path_store
  import path_pkg::*;
#(
  parameter int unsigned MAX_NODES = 32
) (
  input  logic              clk_3125KHz,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  route_entry_t      wdata,
  input  logic [IDX_W-1:0]  rd_idx,
  output route_entry_t      rd_cur,
  output logic [TURN_W-1:0] rd_nxt_turn
);

  route_entry_t mem [MAX_NODES];
  logic [IDX_W-1:0] rd_idx_nxt;

  // Contents are not reset; entries past the loaded length are never consumed.
  always_ff @(posedge clk_3125KHz) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rd_idx_nxt  = IDX_W'(rd_idx + IDX_W'(1));
  assign rd_cur      = mem[rd_idx];
  assign rd_nxt_turn = mem[rd_idx_nxt].turn;

endmodule

// File: rtl/path_sequencer.sv
// Walks a preloaded route node by node, steering the line follower and reporting progress.
module path_sequencer
  import path_pkg::*;
#(
  parameter int unsigned MAX_NODES      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 3125000
) (
  input  logic           clk_3125KHz,
  input  logic           rst,
  path_sequencer_if.slave bus
);

  localparam int unsigned       TCNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(MAX_NODES - 1);

  seq_state_t        state_q, state_nx;
  logic [TURN_W-1:0] turn_q, turn_nx;
  logic [NODE_W-1:0] pos_q, pos_nx;
  logic              end_q, end_nx;
  logic              busy_q, busy_nx;
  logic              fault_q, fault_nx;
  logic [LEN_W-1:0]  len_q, len_nx;
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_nx;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_nx;
  logic              valid_q, valid_nx;
  logic [TCNT_W-1:0] tcnt_q, tcnt_nx;
  logic              node_flag_d;

  logic              load_ready_c;
  logic              accept_c;
  logic              rise_c;
  route_entry_t      wr_entry_c;
  route_entry_t      rd_cur;
  logic [TURN_W-1:0] rd_nxt_turn;

  assign load_ready_c = (state_q == S_IDLE) && !valid_q;
  assign accept_c     = bus.load_valid && load_ready_c;
  assign rise_c       = bus.node_flag && !node_flag_d;
  assign wr_entry_c   = '{node: bus.load_node, turn: bus.load_turn};

  path_store #(.MAX_NODES(MAX_NODES)) u_store (
    .clk_3125KHz (clk_3125KHz),
    .we          (accept_c),
    .waddr       (wr_ptr_q),
    .wdata       (wr_entry_c),
    .rd_idx      (rd_idx_q),
    .rd_cur      (rd_cur),
    .rd_nxt_turn (rd_nxt_turn)
  );

  // Next-state and registered-output values.
  always_comb begin
    state_nx  = state_q;
    turn_nx   = turn_q;
    pos_nx    = pos_q;
    end_nx    = 1'b0;
    busy_nx   = busy_q;
    fault_nx  = fault_q;
    len_nx    = len_q;
    wr_ptr_nx = wr_ptr_q;
    rd_idx_nx = rd_idx_q;
    valid_nx  = valid_q;
    tcnt_nx   = tcnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          wr_ptr_nx = IDX_W'(wr_ptr_q + IDX_W'(1));
          if (bus.load_last || (wr_ptr_q == IDX_LAST)) begin
            valid_nx = 1'b1;
            len_nx   = LEN_W'(LEN_W'(wr_ptr_q) + LEN_W'(1));
          end
        end
        // rd_idx is always zero here, so rd_cur is the first route entry.
        if (bus.start && valid_q) begin
          state_nx  = S_RUN;
          rd_idx_nx = '0;
          turn_nx   = rd_cur.turn;
          busy_nx   = 1'b1;
        end
      end

      S_RUN: begin
        if (rise_c) begin
          state_nx = S_NODE;
          tcnt_nx  = '0;
        end
      end

      S_NODE: begin
        if (bus.node_changed) begin
          pos_nx = rd_cur.node;
          if (LEN_W'(rd_idx_q) == LEN_W'(len_q - LEN_W'(1))) begin
            state_nx  = S_DONE;
            end_nx    = 1'b1;
            turn_nx   = TURN_STRAIGHT;
            busy_nx   = 1'b0;
            valid_nx  = 1'b0;
            wr_ptr_nx = '0;
            rd_idx_nx = '0;
          end else begin
            state_nx  = S_RUN;
            rd_idx_nx = IDX_W'(rd_idx_q + IDX_W'(1));
            turn_nx   = rd_nxt_turn;
          end
        end else if (tcnt_q == TCNT_LAST) begin
          state_nx = S_FAULT;
          fault_nx = 1'b1;
          turn_nx  = TURN_STRAIGHT;
          busy_nx  = 1'b0;
        end else begin
          tcnt_nx = TCNT_W'(tcnt_q + TCNT_W'(1));
        end
      end

      S_DONE:  state_nx = S_IDLE;

      S_FAULT: state_nx = S_FAULT;

      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_3125KHz) begin
    if (rst) begin
      state_q     <= S_IDLE;
      turn_q      <= TURN_STRAIGHT;
      pos_q       <= '0;
      end_q       <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
      len_q       <= '0;
      wr_ptr_q    <= '0;
      rd_idx_q    <= '0;
      valid_q     <= 1'b0;
      tcnt_q      <= '0;
      node_flag_d <= 1'b0;
    end else begin
      state_q     <= state_nx;
      turn_q      <= turn_nx;
      pos_q       <= pos_nx;
      end_q       <= end_nx;
      busy_q      <= busy_nx;
      fault_q     <= fault_nx;
      len_q       <= len_nx;
      wr_ptr_q    <= wr_ptr_nx;
      rd_idx_q    <= rd_idx_nx;
      valid_q     <= valid_nx;
      tcnt_q      <= tcnt_nx;
      node_flag_d <= bus.node_flag;
    end
  end

  assign bus.load_ready   = load_ready_c;
  assign bus.turn_flag    = turn_q;
  assign bus.realtime_pos = pos_q;
  assign bus.end_path     = end_q;
  assign bus.busy         = busy_q;
  assign bus.fault        = fault_q;
  assign bus.path_len     = len_q;

endmodule

// File: tb/tb_path_sequencer.sv
// Randomized bench for path_sequencer against a route-level reference model.
module tb_path_sequencer;
  import path_pkg::*;

  localparam int unsigned TB_MAX     = 32;
  localparam int unsigned TB_TIMEOUT = 16;

  logic clk_3125KHz = 1'b0;
  logic rst;

  always #5 clk_3125KHz = ~clk_3125KHz;

  path_sequencer_if bus ();

  path_sequencer #(.MAX_NODES(TB_MAX), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk_3125KHz (clk_3125KHz),
    .rst         (rst),
    .bus         (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [NODE_W-1:0] r_node [$];
  logic [TURN_W-1:0] r_turn [$];
  logic [NODE_W-1:0] exp_pos;
  int                exp_len;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_3125KHz);
    #1;
  endtask

  function automatic logic [TURN_W-1:0] pick_turn(input int k);
    case (k)
      0:       return TURN_STRAIGHT;
      1:       return TURN_RIGHT;
      2:       return TURN_UTURN;
      default: return TURN_LEFT;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    r_node.delete();
    r_turn.delete();
    exp_pos = '0;
    exp_len = 0;
    check("rst_turn",  32'(bus.turn_flag), 0);
    check("rst_pos",   32'(bus.realtime_pos), 0);
    check("rst_end",   32'(bus.end_path), 0);
    check("rst_busy",  32'(bus.busy), 0);
    check("rst_fault", 32'(bus.fault), 0);
    check("rst_len",   32'(bus.path_len), 0);
    check("rst_ready", 32'(bus.load_ready), 1);
  endtask

  task automatic load_entry(input logic [NODE_W-1:0] node, input logic [TURN_W-1:0] turn,
                            input logic last);
    bus.load_valid = 1'b1;
    bus.load_node  = node;
    bus.load_turn  = turn;
    bus.load_last  = last;
    check("load_ready_on", 32'(bus.load_ready), 1);
    tick();
    r_node.push_back(node);
    r_turn.push_back(turn);
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic finish_load();
    exp_len = r_node.size();
    check("load_ready_off", 32'(bus.load_ready), 0);
    check("path_len", 32'(bus.path_len), 32'(exp_len));
  endtask

  // Random route of n entries; without use_last only a full route terminates the load.
  task automatic load_random(input int n, input bit use_last);
    r_node.delete();
    r_turn.delete();
    for (int i = 0; i < n; i++)
      load_entry(NODE_W'($urandom_range(0, 31)), pick_turn(int'($urandom_range(0, 3))),
                 use_last && (i == n - 1));
    finish_load();
  endtask

  task automatic load_directed();
    r_node.delete();
    r_turn.delete();
    load_entry(5'd5,  TURN_STRAIGHT, 1'b0);
    load_entry(5'd12, TURN_RIGHT,    1'b0);
    load_entry(5'd20, TURN_LEFT,     1'b1);
    finish_load();
  endtask

  task automatic start_route();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_busy", 32'(bus.busy), 1);
    check("start_turn", 32'(bus.turn_flag), 32'(r_turn[0]));
    check("start_len",  32'(bus.path_len), 32'(exp_len));
  endtask

  // One node of the route: random approach, optional stray node_changed, dwell, then leave.
  task automatic visit_node(input int i);
    int gap;
    int dwell;
    gap = int'($urandom_range(0, 3));
    for (int g = 0; g < gap; g++) begin
      bus.node_changed = ($urandom_range(0, 1) == 1);
      tick();
      bus.node_changed = 1'b0;
      check("run_pos_hold", 32'(bus.realtime_pos), 32'(exp_pos));
      check("run_busy", 32'(bus.busy), 1);
    end
    bus.node_flag = 1'b1;
    tick();
    dwell = int'($urandom_range(0, 12));
    for (int d = 0; d < dwell; d++) begin
      tick();
      check("node_pos_hold", 32'(bus.realtime_pos), 32'(exp_pos));
    end
    bus.node_flag    = 1'b0;
    bus.node_changed = 1'b1;
    tick();
    bus.node_changed = 1'b0;
    exp_pos = r_node[i];
    check("pos", 32'(bus.realtime_pos), 32'(exp_pos));
    if (i == r_node.size() - 1) begin
      check("end_hi",    32'(bus.end_path), 1);
      check("end_turn",  32'(bus.turn_flag), 0);
      check("end_busy",  32'(bus.busy), 0);
      tick();
      check("end_lo",    32'(bus.end_path), 0);
      check("idle_ready", 32'(bus.load_ready), 1);
      check("hold_pos",  32'(bus.realtime_pos), 32'(exp_pos));
      check("hold_len",  32'(bus.path_len), 32'(exp_len));
    end else begin
      check("next_turn", 32'(bus.turn_flag), 32'(r_turn[i + 1]));
      check("mid_busy",  32'(bus.busy), 1);
      check("mid_end",   32'(bus.end_path), 0);
    end
  endtask

  task automatic traverse();
    for (int i = 0; i < r_node.size(); i++) visit_node(i);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst              = 1'b1;
    bus.load_valid   = 1'b0;
    bus.load_node    = '0;
    bus.load_turn    = '0;
    bus.load_last    = 1'b0;
    bus.start        = 1'b0;
    bus.node_flag    = 1'b0;
    bus.node_changed = 1'b0;
    exp_pos          = '0;
    exp_len          = 0;
    tick();
    do_reset();

    // Start with nothing loaded is ignored.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("nostart_busy",  32'(bus.busy), 0);
    check("nostart_ready", 32'(bus.load_ready), 1);
    check("nostart_turn",  32'(bus.turn_flag), 0);

    // Directed three-node route; stray node_changed in RUN must not move realtime_pos.
    load_directed();
    start_route();
    bus.node_changed = 1'b1;
    tick();
    bus.node_changed = 1'b0;
    check("run_nc_pos", 32'(bus.realtime_pos), 0);
    traverse();

    // Node timeout.
    do_reset();
    load_directed();
    start_route();
    bus.node_flag = 1'b1;
    tick();
    for (int k = 1; k <= int'(TB_TIMEOUT); k++) begin
      tick();
      if (k == int'(TB_TIMEOUT) - 1) check("fault_early", 32'(bus.fault), 0);
    end
    check("fault_set",  32'(bus.fault), 1);
    check("fault_turn", 32'(bus.turn_flag), 0);
    check("fault_busy", 32'(bus.busy), 0);
    bus.node_flag = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("fault_start_busy", 32'(bus.busy), 0);
    check("fault_sticky", 32'(bus.fault), 1);
    check("fault_ready", 32'(bus.load_ready), 0);
    do_reset();

    // Full-depth route with implicit last entry.
    load_random(32, 1'b0);
    start_route();
    traverse();

    // node_flag already high when RUN is entered must wait for a fresh rising edge.
    load_random(3, 1'b1);
    bus.node_flag = 1'b1;
    tick();
    start_route();
    for (int k = 0; k < int'(TB_TIMEOUT) + 4; k++) begin
      bus.node_changed = (k == 5);
      tick();
    end
    bus.node_changed = 1'b0;
    check("prehigh_fault", 32'(bus.fault), 0);
    check("prehigh_busy",  32'(bus.busy), 1);
    check("prehigh_pos",   32'(bus.realtime_pos), 32'(exp_pos));
    bus.node_flag = 1'b0;
    tick();
    traverse();

    // Reset while sitting in the second node discards the route.
    load_random(4, 1'b1);
    start_route();
    visit_node(0);
    bus.node_flag = 1'b1;
    tick();
    tick();
    do_reset();
    bus.node_flag = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("post_rst_start", 32'(bus.busy), 0);

    // Back-to-back random routes without reset.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(1, 32));
      load_random(n, (n < 32) || ($urandom_range(0, 1) == 1));
      start_route();
      traverse();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
